// File: rtl/wb_sram_pkg.sv
// Types and helpers shared by the Wishbone-to-SRAM bridge.
// Holds the FSM state encoding, the bus/SRAM data widths and the address-window decoder.
package wb_sram_pkg;

   localparam int SRAM_DW = 16;
   localparam int WB_DW   = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RWAIT  = 2'd2,
      ACK    = 2'd3
   } state_e;

   function automatic logic win_match(input logic [WB_DW-1:0] addr,
                                      input logic [WB_DW-1:0] base,
                                      input logic [WB_DW-1:0] mask);
      return (addr & mask) == (base & mask);
   endfunction

endpackage

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave in front of the single-port 16-bit SRAM macro.
// Every SRAM strobe and the ack come straight from flops.
module wb_sram_bridge
   import wb_sram_pkg::*;
#(
   parameter int          AW        = 10,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] BASE_MASK = 32'hFFFF_F000,
   parameter int          READ_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   input  logic [3:0]         wbs_sel_i,
   input  logic [WB_DW-1:0]   wbs_adr_i,
   input  logic [WB_DW-1:0]   wbs_dat_i,
   output logic               wbs_ack_o,
   output logic [WB_DW-1:0]   wbs_dat_o,
   output logic               csb0,
   output logic               web0,
   output logic [1:0]         wmask0,
   output logic [AW-1:0]      addr0,
   output logic [SRAM_DW-1:0] din0,
   input  logic [SRAM_DW-1:0] dout0
);

   if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("wb_sram_bridge: READ_LAT must be within 1..4");
   end

   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_e               state_q;
   logic [1:0]           cnt_q;
   logic                 ack_q;
   logic                 csb_q;
   logic                 web_q;
   logic [1:0]           wmask_q;
   logic [AW-1:0]        addr_q;
   logic [SRAM_DW-1:0]   din_q;
   logic [SRAM_DW-1:0]   rdata_q;
   logic                 req;
   logic                 unused_bits;

   assign req = wbs_cyc_i & wbs_stb_i & win_match(wbs_adr_i, BASE_ADDR, BASE_MASK);

   // Only the low half of the data bus and the low two byte lanes reach the 16-bit macro.
   assign unused_bits = ^{wbs_sel_i[3:2], wbs_dat_i[WB_DW-1:SRAM_DW]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         ack_q   <= 1'b0;
         csb_q   <= 1'b1;
         web_q   <= 1'b1;
         wmask_q <= 2'b00;
         addr_q  <= '0;
         din_q   <= '0;
         rdata_q <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q  <= wbs_adr_i[AW+1:2];
                  din_q   <= wbs_dat_i[SRAM_DW-1:0];
                  wmask_q <= wbs_we_i ? wbs_sel_i[1:0] : 2'b00;
                  web_q   <= ~wbs_we_i;
                  csb_q   <= 1'b0;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               // web_q still carries the direction of the strobe being issued now.
               csb_q <= 1'b1;
               web_q <= 1'b1;
               if (!wbs_cyc_i) begin
                  state_q <= IDLE;
               end else if (!web_q) begin
                  ack_q   <= 1'b1;
                  state_q <= ACK;
               end else begin
                  cnt_q   <= LAT_M1;
                  state_q <= RWAIT;
               end
            end
            RWAIT: begin
               if (!wbs_cyc_i) begin
                  state_q <= IDLE;
               end else if (cnt_q == 2'd0) begin
                  rdata_q <= dout0;
                  ack_q   <= 1'b1;
                  state_q <= ACK;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = {{(WB_DW-SRAM_DW){1'b0}}, rdata_q};
   assign csb0      = csb_q;
   assign web0      = web_q;
   assign wmask0    = wmask_q;
   assign addr0     = addr_q;
   assign din0      = din_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge: one instance with READ_LAT=1 and one with READ_LAT=3,
// each backed by a behavioural SRAM whose read data appears READ_LAT edges after the strobe.
module tb_wb_sram_bridge;
   import wb_sram_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc   [2];
   logic        stb   [2];
   logic        we    [2];
   logic [3:0]  sel   [2];
   logic [31:0] adr   [2];
   logic [31:0] dati  [2];
   logic        ack   [2];
   logic [31:0] dato  [2];
   logic        csb0  [2];
   logic        web0  [2];
   logic [1:0]  wmask0[2];
   logic [9:0]  addr0 [2];
   logic [15:0] din0  [2];
   logic [15:0] dout0 [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;
      logic [15:0] mem  [0:1023];
      logic [15:0] pipe [0:3];

      initial begin
         for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
         for (int i = 0; i < 4; i++) pipe[i] = 16'h0000;
      end

      always @(posedge clk) begin
         if (!csb0[g]) begin
            if (!web0[g]) begin
               if (wmask0[g][0]) mem[addr0[g]][7:0]  <= din0[g][7:0];
               if (wmask0[g][1]) mem[addr0[g]][15:8] <= din0[g][15:8];
            end else begin
               pipe[0] <= mem[addr0[g]];
            end
         end
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end

      assign dout0[g] = pipe[LAT-1];

      wb_sram_bridge #(
         .AW       (10),
         .BASE_ADDR(32'h3000_0000),
         .BASE_MASK(32'hFFFF_F000),
         .READ_LAT (LAT)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .wbs_cyc_i(cyc[g]),
         .wbs_stb_i(stb[g]),
         .wbs_we_i (we[g]),
         .wbs_sel_i(sel[g]),
         .wbs_adr_i(adr[g]),
         .wbs_dat_i(dati[g]),
         .wbs_ack_o(ack[g]),
         .wbs_dat_o(dato[g]),
         .csb0     (csb0[g]),
         .web0     (web0[g]),
         .wmask0   (wmask0[g]),
         .addr0    (addr0[g]),
         .din0     (din0[g]),
         .dout0    (dout0[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Latency is counted from the request cycle T; returns -1 when no ack arrives.
   task automatic do_xfer(input int g, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int lat, output logic [31:0] rd,
                          output logic [1:0] m1, output logic c1);
      @(posedge clk); #1;
      cyc[g] = 1'b1; stb[g] = 1'b1; we[g] = w; adr[g] = a; dati[g] = d; sel[g] = s;
      lat = -1; rd = '0; m1 = 2'b00; c1 = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (n == 1) begin
            m1 = wmask0[g];
            c1 = csb0[g];
         end
         if (ack[g]) begin
            lat = n;
            rd  = dato[g];
            break;
         end
      end
      cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [1:0]  m1;
      logic        c1;
      logic        seen;

      for (int g = 0; g < 2; g++) begin
         cyc[g] = 1'b0; stb[g] = 1'b0; we[g] = 1'b0;
         sel[g] = 4'h0; adr[g] = 32'h0; dati[g] = 32'h0;
      end

      // Reset held with a live request on the bus
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'b0011;
      adr[0] = 32'h3000_0008; dati[0] = 32'h0000_BEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_csb0",   32'(csb0[0]),   32'h1);
      chk("rst_web0",   32'(web0[0]),   32'h1);
      chk("rst_wmask0", 32'(wmask0[0]), 32'h0);
      chk("rst_addr0",  32'(addr0[0]),  32'h0);
      chk("rst_din0",   32'(din0[0]),   32'h0);
      chk("rst_ack",    32'(ack[0]),    32'h0);
      chk("rst_dat_o",  dato[0],        32'h0);
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | ack[0] | ack[1] | ~csb0[0] | ~csb0[1];
      end
      chk("rst_release_quiet", 32'(seen), 32'h0);

      // Full write on the READ_LAT=1 instance, cycle by cycle
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'b0011;
      adr[0] = 32'h3000_0008; dati[0] = 32'h0000_BEEF;
      @(posedge clk); #1;
      chk("wr_t1_csb0",   32'(csb0[0]),   32'h0);
      chk("wr_t1_web0",   32'(web0[0]),   32'h0);
      chk("wr_t1_addr0",  32'(addr0[0]),  32'h2);
      chk("wr_t1_din0",   32'(din0[0]),   32'hBEEF);
      chk("wr_t1_wmask0", 32'(wmask0[0]), 32'h3);
      chk("wr_t1_ack",    32'(ack[0]),    32'h0);
      @(posedge clk); #1;
      chk("wr_t2_ack",    32'(ack[0]),    32'h1);
      chk("wr_t2_csb0",   32'(csb0[0]),   32'h1);
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
      @(posedge clk); #1;
      chk("wr_t3_ack",    32'(ack[0]),    32'h0);

      do_xfer(0, 1'b0, 32'h3000_0008, 32'h0, 4'b0000, lat, rd, m1, c1);
      chk("rd_lat1_cycles", 32'(lat), 32'd3);
      chk("rd_lat1_data",   rd,       32'h0000_BEEF);
      chk("rd_lat1_wmask0", 32'(m1),  32'h0);

      do_xfer(1, 1'b1, 32'h3000_0008, 32'h0000_BEEF, 4'b0011, lat, rd, m1, c1);
      chk("wr_lat3_cycles", 32'(lat), 32'd2);
      do_xfer(1, 1'b0, 32'h3000_0008, 32'h0, 4'b0000, lat, rd, m1, c1);
      chk("rd_lat3_cycles", 32'(lat), 32'd5);
      chk("rd_lat3_data",   rd,       32'h0000_BEEF);

      // Request outside the window
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'b0011;
      adr[0] = 32'h2000_0000; dati[0] = 32'h0000_1111;
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         seen = seen | ack[0] | ~csb0[0];
      end
      chk("miss_no_activity", 32'(seen), 32'h0);
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;

      // Read abandoned in RWAIT on the READ_LAT=3 instance
      do_xfer(1, 1'b1, 32'h3000_000C, 32'h0000_1234, 4'b0011, lat, rd, m1, c1);
      chk("abort_pre_wr", 32'(lat), 32'd2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'b0000; adr[1] = 32'h3000_000C;
      @(posedge clk); #1;
      chk("abort_access_csb0", 32'(csb0[1]), 32'h0);
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", 32'(g_dut[1].u_dut.state_q), 32'(IDLE));
      seen = ack[1];
      repeat (5) begin
         @(posedge clk); #1;
         seen = seen | ack[1];
      end
      chk("abort_no_ack",  32'(seen), 32'h0);
      chk("abort_dat_hold", dato[1],  32'h0000_BEEF);

      // Asynchronous reset while a write strobe is on the SRAM
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'b0011;
      adr[0] = 32'h3000_0014; dati[0] = 32'h0000_5555;
      @(posedge clk); #1;
      chk("rstmid_access_csb0", 32'(csb0[0]), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("rstmid_csb0_async", 32'(csb0[0]), 32'h1);
      chk("rstmid_web0_async", 32'(web0[0]), 32'h1);
      cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | ack[0];
      end
      chk("rstmid_no_ack", 32'(seen), 32'h0);

      // Byte lanes, including a write with no lanes selected
      do_xfer(0, 1'b1, 32'h3000_0010, 32'h0000_ABCD, 4'b0011, lat, rd, m1, c1);
      chk("lane_init_cycles", 32'(lat), 32'd2);
      do_xfer(0, 1'b1, 32'h3000_0010, 32'h0000_12EE, 4'b0010, lat, rd, m1, c1);
      chk("lane_hi_cycles", 32'(lat), 32'd2);
      chk("lane_hi_wmask0", 32'(m1),  32'h2);
      do_xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'b0000, lat, rd, m1, c1);
      chk("lane_hi_readback", rd, 32'h0000_12CD);
      do_xfer(0, 1'b1, 32'h3000_0010, 32'h0000_FFFF, 4'b0000, lat, rd, m1, c1);
      chk("lane_none_cycles", 32'(lat), 32'd2);
      chk("lane_none_wmask0", 32'(m1),  32'h0);
      chk("lane_none_strobe", 32'(c1),  32'h0);
      do_xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'b0000, lat, rd, m1, c1);
      chk("lane_none_readback", rd, 32'h0000_12CD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_sram_bridge.md
Name: wb_sram_bridge

Overview:
Wishbone classic slave that fronts the SoC's shared 16-bit SRAM port (the `web`/`wmask0`/`addr0`/`din0`/`dout0` interface the management core writes program/data through). It sits directly upstream of natalius_soc's memory port. It also closes the currently open `wbs_ack_o` path.
- Decodes an address window and sequences single-port SRAM strobes.
- Waits out the macro's read latency, returns read data, and generates a single-cycle ack.

Parameters:
- AW, 10, SRAM word-address width (SRAM depth = 2**AW words).
- BASE_ADDR, 32'h3000_0000, Wishbone byte address of SRAM word 0.
- BASE_MASK, 32'hFFFF_F000, bits compared against BASE_ADDR for window match.
- READ_LAT, 1, SRAM clock cycles from csb0-low edge to valid dout0 (1..4).

Ports:
- clk  in  1  system clock (wb_clk_i)
- rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  1=write
- wbs_sel_i  in  4  byte selects; only [1:0] used
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data; only [15:0] used
- wbs_ack_o  out  1  transfer acknowledge
- wbs_dat_o  out  32  read data, {16'h0000, word}
- csb0  out  1  SRAM chip select, active low
- web0  out  1  SRAM write enable, active low
- wmask0  out  2  SRAM byte-lane mask
- addr0  out  AW  SRAM word address
- din0  out  16  SRAM write data
- dout0  in  16  SRAM read data

Behaviour:
- Reset (async, rst_n=0) forces the following immediately, independent of clk:
  - state IDLE
  - csb0=1, web0=1, wmask0=0, addr0=0, din0=0
  - wbs_ack_o=0, wbs_dat_o=0, latency counter=0
- Reset asserted mid-transfer: transfer abandoned, no ack ever issued for it.
- Window match: hit = ((wbs_adr_i & BASE_MASK) == (BASE_ADDR & BASE_MASK)).
- Word mapping: addr0 = wbs_adr_i[AW+1:2]. Each 32-bit bus word maps to one 16-bit SRAM word.
- A request is cyc & stb & hit. Non-hit requests are ignored entirely: no ack, no SRAM activity.
- All SRAM-side outputs and wbs_ack_o are registered.
- States:
  - IDLE
    - On a request: latch addr0, din0 (= dat_i[15:0]), wmask0 (= sel[1:0] if we, else 2'b00), web0 (= ~we); set csb0=0; go to ACCESS.
  - ACCESS (csb0=0 for exactly this one cycle)
    - Next edge: csb0=1, web0=1.
    - If write: go to ACK.
    - If read: load counter with READ_LAT-1 and go to RWAIT.
  - RWAIT
    - Decrement the counter.
    - When counter==0: capture dout0 into wbs_dat_o[15:0] with [31:16]=0, and go to ACK.
  - ACK
    - wbs_ack_o=1 for exactly one cycle, then go to IDLE.
- Latency, with the request first visible in cycle T:
  - csb0 low in T+1.
  - Write: ack in T+2.
  - Read: ack in T+2+READ_LAT.
- Back-to-back: in the cycle after ACK, IDLE may accept a new request. Minimum 3 cycles per write, 3+READ_LAT per read.
- Abort: if cyc drops in ACCESS or RWAIT, return to IDLE with no ack.
  - A write already strobed in ACCESS stays committed.
  - Read data is not captured.
- ACK is unconditional once reached (already registered).
- wmask0 when sel[1:0]==2'b00 on a write: the strobe is still issued (SRAM unchanged) and the transfer is acked normally.
- wbs_dat_o holds the last read value until the next read capture. Writes do not alter it.
- READ_LAT outside 1..4: elaboration-time error.
- The counter is 2 bits wide.

Decomposition:
- Shared package wb_sram_pkg:
  - state enum {IDLE, ACCESS, RWAIT, ACK}
  - SRAM_DW=16, WB_DW=32 constants
  - a window-match function taking addr, base, mask.
- No sub-module is natural: single FSM plus counter, roughly 150–200 lines.

Test Plan:
- Reset: hold rst_n=0 with stb=1 -> all outputs at reset values. Release -> no spurious ack.
- Write 32'h3000_0008, dat 32'h0000_BEEF, sel 4'b0011 -> in T+1: csb0=0, web0=0, addr0=2, din0=16'hBEEF, wmask0=2'b11. Ack in T+2 only.
- Read same address, SRAM model returns 16'hBEEF after 1 cycle (READ_LAT=1) -> ack in T+3 with wbs_dat_o=32'h0000_BEEF. Repeat with READ_LAT=3 -> ack in T+5.
- Access 32'h2000_0000 (outside window) for 10 cycles -> csb0 stays 1, wbs_ack_o stays 0.
- Read, then drop cyc in RWAIT (READ_LAT=3) -> no ack, wbs_dat_o keeps previous value, FSM in IDLE next cycle. Then assert rst_n=0 during ACCESS of a write -> csb0 returns to 1 immediately (async).
- Byte-lane write sel 4'b0010, dat 16'h12xx -> wmask0=2'b10. Readback shows only the upper byte changed.
